result_drain: RTL and testbench
===============================

# result_drain

Downstream neighbour of the tensor-core operand sequencer (`state_machine`) and its 2x2 systolic PE array. When the array signals that a tile is complete, this block snapshots the four accumulators and releases the array with a one-cycle clear. It then streams the results out over a valid/ready word interface, either as four sign-extended 32-bit words or as two words of packed saturated int16. It also flags tile overruns and counts drained tiles.

## Interface
- ACC_W, 24, accumulator width of each PE output (signed); legal range 16..32
- CNT_W, 16, width of drained-tile counter
- clk  in  1  clock; all logic on rising edge
- reset  in  1  synchronous, active-low reset
- done_in  in  1  tile-complete pulse from array/sequencer; c11..c22 valid in the same cycle
- c11, c12, c21, c22  in  ACC_W each  signed accumulator results
- pack16  in  1  output format, sampled only at capture: 0 = 4 x int32, 1 = 2 x packed int16
- err_clr  in  1  clears overrun flag
- acc_clr  out  1  one-cycle pulse to zero the PE accumulators
- busy  out  1  high while a captured tile is not fully drained
- out_valid  out  1  out_data holds a valid word
- out_data  out  32  result word
- out_last  out  1  marks the final word of a tile; qualified by out_valid
- out_ready  in  1  consumer accepts the word when out_valid && out_ready
- overrun  out  1  sticky: done_in arrived while busy and was dropped
- tile_cnt  out  CNT_W  number of fully drained tiles; wraps modulo 2^CNT_W

## Operation
- States: IDLE, EMIT. Word index idx is 2 bits. Word count n is 4 (pack16=0) or 2 (pack16=1).
- IDLE, done_in=1:
  - snapshot c11..c22 and pack16 into holding regs
  - idx <- 0
  - go to EMIT
  - pulse acc_clr next cycle
- EMIT: out_valid=1, out_data = word[idx].
  - Handshake with idx < n-1: idx++.
  - Handshake with idx = n-1: tile_cnt++ and return to IDLE.
- pack16=0 words, in order: c11, c12, c21, c22, each sign-extended from ACC_W to 32 bits.
- pack16=1 words, in order: {sat(c12), sat(c11)}, then {sat(c22), sat(c21)}.
  - sat() clamps to [-32768, 32767] and keeps the low 16 bits.
  - First-named element sits in [31:16].
- out_last = out_valid && (idx == n-1).
- Last handshake coincident with done_in: capture the new tile, stay in EMIT with idx <- 0, pulse acc_clr. This is not an overrun, and tile_cnt still increments.
- done_in in EMIT with no last-word handshake in that cycle:
  - tile is dropped; holding regs and idx are unchanged
  - no acc_clr pulse
  - overrun <- 1
- err_clr clears overrun. If err_clr and a new overrun event occur in the same cycle, the set wins.
- out_data is stable while out_valid && !out_ready, and remains stable through consumer stalls of any length.
- busy = (state == EMIT).
- Mid-operation reset (reset=0): abandons any tile in flight with no further handshakes.

## Timing
- Reset values: state IDLE, idx 0, acc_clr 0, out_valid 0, out_last 0, out_data 0, busy 0, overrun 0, tile_cnt 0. Holding regs are 0.
- Capture latency: done_in sampled at edge N. out_valid, word0, busy and acc_clr are all visible after edge N.
- acc_clr is high for exactly one cycle per accepted tile.
- Throughput: with out_ready held high, one word per cycle. A tile drains in n cycles, and back-to-back tiles have no bubble.
- Inputs c11..c22 are only required to be valid in the done_in cycle.
- All outputs are registered. There is no combinational path from out_ready to out_valid, and none from out_ready to out_data.

## Test plan
- Reset, then idle: all outputs 0. Then done_in with c11=5, c12=-3, c21=100000, c22=-1, pack16=0, out_ready=1 -> acc_clr pulse at cycle 1. Words 0x00000005, 0xFFFFFFFD, 0x000186A0, 0xFFFFFFFF on cycles 1-4, out_last on the 4th, tile_cnt=1.
- pack16=1 with c11=40000, c12=-40000, c21=-7, c22=12 -> words 0x80007FFF then 0x000CFFF9, out_last on the 2nd word.
- Stall: out_ready low for 5 cycles mid-tile -> out_data and idx hold, no lost or duplicated words.
- Overrun: second done_in during word 1 -> overrun=1, words still match the first tile, only one acc_clr pulse. Then err_clr -> overrun=0.
- Back-to-back: done_in coincident with the last-word handshake -> no overrun, acc_clr pulses, the second tile's words follow with no gap, tile_cnt=2.
- reset=0 asserted mid-drain -> next cycle out_valid=0, busy=0, tile_cnt=0. A subsequent tile drains normally. tile_cnt wraps 0xFFFF -> 0x0000.

Source files
------------

// File: rtl/result_drain.sv
// Result drain for the 2x2 systolic array: snapshots a finished tile, clears the
// accumulators, and streams the results as int32 words or packed saturated int16 pairs.
module result_drain #(
    parameter int ACC_W = 24,
    parameter int CNT_W = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    done_in,
    input  logic signed [ACC_W-1:0] c11,
    input  logic signed [ACC_W-1:0] c12,
    input  logic signed [ACC_W-1:0] c21,
    input  logic signed [ACC_W-1:0] c22,
    input  logic                    pack16,
    input  logic                    err_clr,
    output logic                    acc_clr,
    output logic                    busy,
    output logic                    out_valid,
    output logic [31:0]             out_data,
    output logic                    out_last,
    input  logic                    out_ready,
    output logic                    overrun,
    output logic [CNT_W-1:0]        tile_cnt
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        EMIT = 1'b1
    } state_t;

    state_t                  state_r, state_s;
    logic [1:0]              idx_r, idx_s;
    logic signed [ACC_W-1:0] h11_r, h12_r, h21_r, h22_r;
    logic signed [ACC_W-1:0] h11_s, h12_s, h21_s, h22_s;
    logic                    pack_r, pack_s;
    logic                    hs_s, last_s, fin_s, cap_s, ovr_set_s;

    function automatic logic [15:0] sat16(input logic signed [ACC_W-1:0] v);
        logic signed [31:0] w;
        logic [15:0]        r;
        w = 32'(v);
        if (w > 32'sd32767) begin
            r = 16'h7FFF;
        end else if (w < -32'sd32768) begin
            r = 16'h8000;
        end else begin
            r = w[15:0];
        end
        return r;
    endfunction

    function automatic logic [1:0] last_idx(input logic pk);
        logic [1:0] r;
        if (pk) begin
            r = 2'd1;
        end else begin
            r = 2'd3;
        end
        return r;
    endfunction

    function automatic logic [31:0] word_sel(
        input logic                    pk,
        input logic [1:0]              ix,
        input logic signed [ACC_W-1:0] a11,
        input logic signed [ACC_W-1:0] a12,
        input logic signed [ACC_W-1:0] a21,
        input logic signed [ACC_W-1:0] a22
    );
        logic [31:0] w;
        w = 32'h0000_0000;
        if (pk) begin
            case (ix)
                2'd0:    w = {sat16(a12), sat16(a11)};
                2'd1:    w = {sat16(a22), sat16(a21)};
                default: w = 32'h0000_0000;
            endcase
        end else begin
            case (ix)
                2'd0:    w = 32'(a11);
                2'd1:    w = 32'(a12);
                2'd2:    w = 32'(a21);
                2'd3:    w = 32'(a22);
                default: w = 32'h0000_0000;
            endcase
        end
        return w;
    endfunction

    // Next-state: a capture on the final handshake restarts EMIT without a bubble.
    always_comb begin
        hs_s      = (state_r == EMIT) && out_ready;
        last_s    = (idx_r == last_idx(pack_r));
        fin_s     = hs_s && last_s;
        cap_s     = done_in && ((state_r == IDLE) || fin_s);
        ovr_set_s = done_in && !cap_s;
        state_s   = state_r;
        idx_s     = idx_r;
        h11_s     = h11_r;
        h12_s     = h12_r;
        h21_s     = h21_r;
        h22_s     = h22_r;
        pack_s    = pack_r;
        if (cap_s) begin
            state_s = EMIT;
            idx_s   = 2'd0;
            h11_s   = c11;
            h12_s   = c12;
            h21_s   = c21;
            h22_s   = c22;
            pack_s  = pack16;
        end else if (fin_s) begin
            state_s = IDLE;
        end else if (hs_s) begin
            idx_s = idx_r + 2'd1;
        end else begin
            idx_s = idx_r;
        end
    end

    // State, holding registers and all outputs; outputs come from next-state values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r   <= IDLE;
            idx_r     <= 2'd0;
            h11_r     <= '0;
            h12_r     <= '0;
            h21_r     <= '0;
            h22_r     <= '0;
            pack_r    <= 1'b0;
            acc_clr   <= 1'b0;
            busy      <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= 32'h0000_0000;
            overrun   <= 1'b0;
            tile_cnt  <= '0;
        end else begin
            state_r   <= state_s;
            idx_r     <= idx_s;
            h11_r     <= h11_s;
            h12_r     <= h12_s;
            h21_r     <= h21_s;
            h22_r     <= h22_s;
            pack_r    <= pack_s;
            acc_clr   <= cap_s;
            busy      <= (state_s == EMIT);
            out_valid <= (state_s == EMIT);
            out_last  <= (state_s == EMIT) && (idx_s == last_idx(pack_s));
            if (state_s == EMIT) begin
                out_data <= word_sel(pack_s, idx_s, h11_s, h12_s, h21_s, h22_s);
            end else begin
                out_data <= 32'h0000_0000;
            end
            if (ovr_set_s) begin
                overrun <= 1'b1;
            end else if (err_clr) begin
                overrun <= 1'b0;
            end else begin
                overrun <= overrun;
            end
            if (fin_s) begin
                tile_cnt <= tile_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
                tile_cnt <= tile_cnt;
            end
        end
    end

endmodule

// File: tb/tb_result_drain.sv
// Self-checking bench for result_drain: vector table, directed corner sequences and
// randomized traffic compared every cycle against a queue-based tile model.
module tb_result_drain;

    localparam int ACC_W = 24;
    localparam int CNT_W = 4;

    logic                    clk = 1'b0;
    logic                    reset = 1'b0;
    logic                    done_in = 1'b0;
    logic signed [ACC_W-1:0] c11 = '0, c12 = '0, c21 = '0, c22 = '0;
    logic                    pack16 = 1'b0;
    logic                    err_clr = 1'b0;
    logic                    acc_clr, busy, out_valid, out_last, overrun;
    logic [31:0]             out_data;
    logic                    out_ready = 1'b0;
    logic [CNT_W-1:0]        tile_cnt;

    result_drain #(.ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset), .done_in(done_in),
        .c11(c11), .c12(c12), .c21(c21), .c22(c22),
        .pack16(pack16), .err_clr(err_clr), .acc_clr(acc_clr), .busy(busy),
        .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
        .out_ready(out_ready), .overrun(overrun), .tile_cnt(tile_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Current accumulator values as plain integers (the model reads these).
    int iv11 = 0, iv12 = 0, iv21 = 0, iv22 = 0;

    // Reference model: pending words of the tile in flight.
    logic [31:0] q[$];
    int          m_cnt = 0;
    bit          m_ovr = 1'b0;
    bit          m_clr = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_sat(input int v);
        int t;
        if (v > 32767) t = 32767;
        else if (v < -32768) t = -32768;
        else t = v;
        return t[15:0];
    endfunction

    task automatic model_edge();
        bit hs, fin, cap;
        if (!reset) begin
            q.delete();
            m_cnt = 0;
            m_ovr = 1'b0;
            m_clr = 1'b0;
            return;
        end
        hs  = (q.size() != 0) && out_ready;
        fin = hs && (q.size() == 1);
        cap = done_in && ((q.size() == 0) || fin);
        if (done_in && !cap) m_ovr = 1'b1;
        else if (err_clr) m_ovr = 1'b0;
        if (hs) void'(q.pop_front());
        if (fin) m_cnt = (m_cnt + 1) % (1 << CNT_W);
        if (cap) begin
            if (pack16) begin
                q.push_back({m_sat(iv12), m_sat(iv11)});
                q.push_back({m_sat(iv22), m_sat(iv21)});
            end else begin
                q.push_back(32'(iv11));
                q.push_back(32'(iv12));
                q.push_back(32'(iv21));
                q.push_back(32'(iv22));
            end
        end
        m_clr = cap;
    endtask

    task automatic check_all();
        chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
        chk("busy", 32'(busy), 32'(q.size() != 0));
        chk("out_last", 32'(out_last), 32'(q.size() == 1));
        chk("acc_clr", 32'(acc_clr), 32'(m_clr));
        chk("overrun", 32'(overrun), 32'(m_ovr));
        chk("tile_cnt", 32'(tile_cnt), 32'(m_cnt));
        if (q.size() != 0) chk("out_data", out_data, q[0]);
    endtask

    // One clock: model steps at the edge, DUT compared on the falling edge.
    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check_all();
    endtask

    task automatic set_c(input int a, input int b, input int c, input int d);
        iv11 = a; iv12 = b; iv21 = c; iv22 = d;
        c11 = a[ACC_W-1:0];
        c12 = b[ACC_W-1:0];
        c21 = c[ACC_W-1:0];
        c22 = d[ACC_W-1:0];
    endtask

    task automatic run_tile(input int a, input int b, input int c, input int d, input bit pk);
        set_c(a, b, c, d);
        pack16 = pk; done_in = 1'b1; out_ready = 1'b1;
        cyc();
        done_in = 1'b0;
        repeat (pk ? 2 : 4) cyc();
    endtask

    function automatic int rand_val();
        int r, sel;
        sel = int'($urandom_range(0, 7));
        r   = $urandom;
        case (sel)
            0:       return (1 <<< (ACC_W - 1)) - 1;
            1:       return -(1 <<< (ACC_W - 1));
            2:       return int'($urandom_range(0, 80000)) - 40000;
            default: return r >>> (32 - ACC_W);
        endcase
    endfunction

    typedef struct {
        int          a, b, c, d;
        bit          pk;
        int          n;
        logic [31:0] w[4];
    } vec_t;

    vec_t        tbl[4];
    logic [31:0] save;

    initial begin
        tbl[0] = '{a: 5, b: -3, c: 100000, d: -1, pk: 1'b0, n: 4,
                   w: '{32'h0000_0005, 32'hFFFF_FFFD, 32'h0001_86A0, 32'hFFFF_FFFF}};
        tbl[1] = '{a: 40000, b: -40000, c: -7, d: 12, pk: 1'b1, n: 2,
                   w: '{32'h8000_7FFF, 32'h000C_FFF9, 32'h0, 32'h0}};
        tbl[2] = '{a: 32767, b: -32768, c: 32768, d: -32769, pk: 1'b1, n: 2,
                   w: '{32'h8000_7FFF, 32'h8000_7FFF, 32'h0, 32'h0}};
        tbl[3] = '{a: 8388607, b: -8388608, c: 0, d: 1, pk: 1'b0, n: 4,
                   w: '{32'h007F_FFFF, 32'hFF80_0000, 32'h0000_0000, 32'h0000_0001}};

        // Reset, then idle with everything low.
        reset = 1'b0;
        repeat (2) cyc();
        reset = 1'b1;
        cyc();
        chk("rst_valid", 32'(out_valid), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_data", out_data, 32'h0);
        chk("rst_acc_clr", 32'(acc_clr), 32'h0);
        chk("rst_tile_cnt", 32'(tile_cnt), 32'h0);

        // Table of known tiles, drained with out_ready high.
        for (int i = 0; i < 4; i++) begin
            set_c(tbl[i].a, tbl[i].b, tbl[i].c, tbl[i].d);
            pack16 = tbl[i].pk; done_in = 1'b1; out_ready = 1'b1;
            cyc();
            chk("tbl_acc_clr", 32'(acc_clr), 32'h1);
            done_in = 1'b0;
            for (int k = 0; k < tbl[i].n; k++) begin
                chk("tbl_word", out_data, tbl[i].w[k]);
                chk("tbl_last", 32'(out_last), 32'(k == tbl[i].n - 1));
                cyc();
            end
            chk("tbl_tile_cnt", 32'(tile_cnt), 32'(i + 1));
        end

        // Stall: out_ready low for 5 cycles mid-tile.
        set_c(11, 22, 33, 44); pack16 = 1'b0; done_in = 1'b1; out_ready = 1'b1;
        cyc();
        done_in = 1'b0;
        cyc();
        save = out_data;
        out_ready = 1'b0;
        repeat (5) begin
            cyc();
            chk("stall_hold", out_data, save);
        end
        out_ready = 1'b1;
        repeat (3) cyc();

        // Overrun: second done_in during word 1 is dropped.
        set_c(1, 2, 3, 4); done_in = 1'b1;
        cyc();
        done_in = 1'b0;
        cyc();
        set_c(91, 92, 93, 94); done_in = 1'b1;
        cyc();
        chk("ovr_set", 32'(overrun), 32'h1);
        chk("ovr_no_clr", 32'(acc_clr), 32'h0);
        chk("ovr_word2", out_data, 32'h0000_0003);
        done_in = 1'b0;
        repeat (2) cyc();
        err_clr = 1'b1;
        cyc();
        chk("ovr_cleared", 32'(overrun), 32'h0);
        err_clr = 1'b0;

        // Back-to-back: done_in coincident with the last handshake.
        set_c(-100000, 50, 7, -8); pack16 = 1'b1; done_in = 1'b1;
        cyc();
        done_in = 1'b0;
        cyc();
        set_c(70000, -2, 3, -4); pack16 = 1'b0; done_in = 1'b1;
        cyc();
        chk("b2b_acc_clr", 32'(acc_clr), 32'h1);
        chk("b2b_no_ovr", 32'(overrun), 32'h0);
        chk("b2b_word0", out_data, 32'h0001_1170);
        done_in = 1'b0;
        repeat (3) begin
            cyc();
            chk("b2b_no_gap", 32'(out_valid), 32'h1);
        end
        cyc();

        // Reset mid-drain abandons the tile.
        set_c(5, 6, 7, 8); done_in = 1'b1;
        cyc();
        done_in = 1'b0;
        cyc();
        reset = 1'b0;
        cyc();
        chk("mrst_valid", 32'(out_valid), 32'h0);
        chk("mrst_busy", 32'(busy), 32'h0);
        chk("mrst_tile_cnt", 32'(tile_cnt), 32'h0);
        reset = 1'b1;

        // Counter wrap through all-ones.
        for (int t = 0; t < (1 << CNT_W) - 1; t++) run_tile(t, -t, 2 * t, 40000, 1'b1);
        chk("wrap_max", 32'(tile_cnt), 32'((1 << CNT_W) - 1));
        run_tile(1, 2, 3, 4, 1'b0);
        chk("wrap_zero", 32'(tile_cnt), 32'h0);

        // Randomized traffic against the model.
        for (int r = 0; r < 3000; r++) begin
            set_c(rand_val(), rand_val(), rand_val(), rand_val());
            pack16    = 1'($urandom_range(0, 1));
            done_in   = ($urandom_range(0, 3) == 0);
            out_ready = ($urandom_range(0, 3) != 0);
            err_clr   = ($urandom_range(0, 19) == 0);
            reset     = ($urandom_range(0, 499) != 0);
            cyc();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
